// File: rtl/scope_capture_pkg.sv
// Shared definitions for the triggered capture buffer: state encoding,
// default geometry and the derived post-trigger sample count.
package scope_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRE_FILL  = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_READOUT   = 3'd4
  } state_t;

  localparam int DW_DEFAULT  = 8;
  localparam int AW_DEFAULT  = 6;
  localparam int PRE_DEFAULT = 16;

  // Samples written after the trigger sample so the window fills the whole buffer.
  function automatic int post_count(input int aw, input int pre);
    return (1 << aw) - pre - 1;
  endfunction

  localparam int POST_CNT = post_count(AW_DEFAULT, PRE_DEFAULT);

endpackage

// File: rtl/scope_capture_ram.sv
// Capture memory: simple dual-port, synchronous write, registered read.
// Only the read register is reset so the array itself can map to block RAM.
module capture_ram #(
  parameter int DW = 8,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Store the incoming sample on the write strobe.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; holds its last value between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/scope_capture.sv
// Triggered sample-capture buffer. Keeps PRE samples of history, waits for a
// rising crossing of level, fills the rest of the buffer, then drains the
// window oldest-first on the read port.
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_IDLE      | no writes; waiting for arm
// ST_PRE_FILL  | writing the first PRE samples, trigger not evaluated
// ST_WAIT_TRIG | circular writes, looking for prev < level <= sample
// ST_POST      | writing the post-trigger part of the window
// ST_READOUT   | draining the window on rd_en; sample_en ignored
module scope_capture
  import scope_capture_pkg::*;
#(
  parameter int DW  = DW_DEFAULT,
  parameter int AW  = AW_DEFAULT,
  parameter int PRE = PRE_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] sample,
  input  logic          sample_en,
  input  logic [DW-1:0] level,
  input  logic          arm,
  output logic          armed,
  output logic          triggered,
  output logic          done,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          rd_last
);

  localparam logic [AW-1:0] PRE_OFS   = AW'(PRE);
  localparam logic [AW-1:0] PRE_LAST  = AW'(PRE - 1);
  localparam logic [AW-1:0] POST_LAST = AW'(post_count(AW, PRE) - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr, trig_ptr, cnt, rd_cnt;
  logic [DW-1:0] prev;
  logic          capturing, wr_en, trig_hit, rd_fire, rd_final;

  assign capturing = (state == ST_PRE_FILL) || (state == ST_WAIT_TRIG) || (state == ST_POST);
  assign wr_en     = capturing && sample_en;
  // prev holds the last accepted sample, including the final pre-fill one.
  assign trig_hit  = (state == ST_WAIT_TRIG) && sample_en && (prev < level) && (sample >= level);
  assign rd_fire   = (state == ST_READOUT) && rd_en;
  assign rd_final  = rd_fire && (rd_cnt == {AW{1'b1}});

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (arm) state_nxt = ST_PRE_FILL;
      ST_PRE_FILL:  if (wr_en && (cnt == PRE_LAST)) state_nxt = ST_WAIT_TRIG;
      ST_WAIT_TRIG: if (trig_hit) state_nxt = ST_POST;
      ST_POST:      if (wr_en && (cnt == POST_LAST)) state_nxt = ST_READOUT;
      ST_READOUT:   if (rd_final) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    armed     = capturing;
    triggered = (state == ST_POST) || (state == ST_READOUT);
    done      = (state == ST_READOUT);
  end

  // Pointers, phase counters and the previous-sample register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      trig_ptr <= '0;
      cnt      <= '0;
      rd_cnt   <= '0;
      prev     <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        prev   <= sample;
      end
      case (state)
        ST_IDLE: begin
          if (arm) begin
            wr_ptr <= '0;
            cnt    <= '0;
          end
        end
        ST_PRE_FILL: begin
          if (wr_en) begin
            if (cnt == PRE_LAST) cnt <= '0;
            else                 cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_TRIG: begin
          if (trig_hit) begin
            trig_ptr <= wr_ptr;
            cnt      <= '0;
          end
        end
        ST_POST: begin
          if (wr_en) begin
            cnt <= cnt + 1'b1;
            if (cnt == POST_LAST) begin
              rd_ptr <= trig_ptr - PRE_OFS;
              rd_cnt <= '0;
            end
          end
        end
        ST_READOUT: begin
          if (rd_fire) begin
            rd_ptr <= rd_ptr + 1'b1;
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Read qualifiers line up with the registered RAM output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      rd_last  <= rd_final;
    end
  end

  capture_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (sample),
    .rd_en   (rd_fire),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_scope_capture.sv
// Directed bench for scope_capture: sawtooth and square captures, ignored
// requests, gapped readout, reset mid-capture and the never-trigger level.
module tb_scope_capture;
  import scope_capture_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int PRE   = 16;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] sample;
  logic          sample_en;
  logic [DW-1:0] level;
  logic          arm;
  logic          armed, triggered, done;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid, rd_last;

  always #5 clk = ~clk;

  scope_capture #(.DW(DW), .AW(AW), .PRE(PRE)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sample    (sample),
    .sample_en (sample_en),
    .level     (level),
    .arm       (arm),
    .armed     (armed),
    .triggered (triggered),
    .done      (done),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_last   (rd_last)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Waveform generator: mode 1 sawtooth 0..63, mode 2 square 0/255 with a
  // 10-sample half-period. Values advance per strobed sample, strobe every gen_div cycles.
  int gen_mode  = 0;
  int gen_div   = 1;
  int gen_phase = 0;
  int gen_idx   = 0;

  function automatic logic [7:0] gen_val(input int mode, input int idx);
    if (mode == 1) return 8'(idx % 64);
    return (((idx / 10) % 2) == 1) ? 8'd255 : 8'd0;
  endfunction

  always @(negedge clk) begin
    if (gen_mode != 0 && gen_phase == 0) begin
      sample_en = 1'b1;
      sample    = gen_val(gen_mode, gen_idx);
      gen_idx++;
    end else begin
      sample_en = 1'b0;
      sample    = 8'hA5;
    end
    gen_phase = (gen_phase + 1 >= gen_div) ? 0 : gen_phase + 1;
  end

  // Record every strobed sample from the first PRE_FILL cycle onward.
  logic [7:0] acc_q[$];
  bit         rec_on = 0;
  always @(posedge clk) begin
    if (rec_on && sample_en) acc_q.push_back(sample);
  end

  logic [7:0] exp_win [DEPTH];
  logic [7:0] got_win [DEPTH];

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input int mode, input int div);
    @(posedge clk); #1;
    arm = 1'b1; rec_on = 0; gen_mode = mode; gen_div = div;
    @(posedge clk); #1;
    arm = 1'b0; acc_q.delete(); gen_idx = 0; gen_phase = 0; rec_on = 1;
    chk("armed_after_arm", armed, 1);
  endtask

  task automatic wait_trig(input int budget, input string tag);
    int n = 0;
    while (triggered !== 1'b1 && n < budget) begin step(); n++; end
    chk(tag, triggered, 1);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin step(); n++; end
    chk(tag, done, 1);
  endtask

  task automatic fill_saw_expected();
    for (int i = 0; i < DEPTH; i++) exp_win[i] = 8'((16 + i) % 64);
  endtask

  // Reference capture: first rising crossing at or after sample PRE,
  // window is PRE samples before it through the end of the buffer.
  task automatic build_expected(input logic [7:0] lv, output bit ok);
    ok = 0;
    for (int k = PRE; k < acc_q.size(); k++) begin
      if (!ok && acc_q[k-1] < lv && acc_q[k] >= lv && (k - PRE + DEPTH) <= acc_q.size()) begin
        for (int i = 0; i < DEPTH; i++) exp_win[i] = acc_q[k - PRE + i];
        ok = 1;
      end
    end
  endtask

  task automatic read_window(input int period, input int ncyc, input string tag);
    int nval  = 0;
    int nlast = 0;
    for (int i = 0; i < DEPTH; i++) got_win[i] = 'x;
    for (int c = 0; c < ncyc; c++) begin
      rd_en = ((c % period) == 0);
      step();
      if (rd_valid === 1'b1) begin
        if (nval < DEPTH) begin
          got_win[nval] = rd_data;
          chk($sformatf("%s_data[%0d]", tag, nval), rd_data, exp_win[nval]);
          chk($sformatf("%s_last[%0d]", tag, nval), rd_last, (nval == DEPTH - 1));
        end
        nval++;
      end
      if (rd_last === 1'b1) nlast++;
    end
    rd_en = 1'b0;
    step();
    chk({tag, "_valid_count"}, nval, DEPTH);
    chk({tag, "_last_count"}, nlast, 1);
    chk({tag, "_valid_after"}, rd_valid, 0);
    chk({tag, "_done_after"}, done, 0);
    chk({tag, "_trig_after"}, triggered, 0);
    chk({tag, "_armed_after"}, armed, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_armed"}, armed, 0);
    chk({tag, "_triggered"}, triggered, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_last"}, rd_last, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    bit trig_seen;
    reset_n = 1'b0; arm = 1'b0; rd_en = 1'b0; level = '0;
    step(2);
    chk_all_zero("reset");
    reset_n = 1'b1;
    step(2);

    // Sawtooth capture with ignored requests along the way.
    level = 8'd32;
    do_arm(1, 1);
    step(20);
    chk("saw_wait_armed", armed, 1);
    chk("saw_wait_not_trig", triggered, 0);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("rd_en_ignored_wait", rd_valid, 0);
    step();
    chk("rd_en_ignored_wait2", rd_valid, 0);
    wait_trig(100, "saw_trig");
    chk("saw_post_armed", armed, 1);
    arm = 1'b1; step(); arm = 1'b0;
    chk("arm_ignored_post", armed, 1);
    chk("arm_ignored_post_done", done, 0);
    wait_done(200, "saw_done");
    chk("saw_done_armed", armed, 0);
    chk("saw_done_trig", triggered, 1);
    arm = 1'b1; step(); arm = 1'b0;
    chk("arm_ignored_readout", done, 1);
    chk("arm_ignored_readout_armed", armed, 0);
    fill_saw_expected();
    read_window(1, 70, "saw");

    // Square wave with a strobe every third cycle, gapped readout.
    level = 8'd128;
    do_arm(2, 3);
    wait_done(400, "sq_done");
    build_expected(level, ok);
    chk("sq_model_trigger_found", ok, 1);
    read_window(3, 200, "sq");
    chk("sq_idx16", got_win[16], 255);
    chk("sq_idx15", got_win[15], 0);

    // Reset in the middle of POST, then repeat the sawtooth capture.
    level = 8'd32;
    do_arm(1, 1);
    wait_trig(100, "rst_trig");
    step(10);
    chk("rst_in_post", triggered, 1);
    reset_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    step(2);
    chk_all_zero("rst_hold");
    reset_n = 1'b1;
    step();
    do_arm(1, 1);
    wait_done(200, "rerun_done");
    fill_saw_expected();
    read_window(1, 70, "rerun");

    // Level 0 never triggers; a further arm changes nothing.
    level = 8'd0;
    do_arm(1, 1);
    trig_seen = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (triggered !== 1'b0) trig_seen = 1;
    end
    chk("lvl0_no_trigger", trig_seen, 0);
    chk("lvl0_armed", armed, 1);
    arm = 1'b1; step(); arm = 1'b0;
    step(5);
    chk("lvl0_rearm_armed", armed, 1);
    chk("lvl0_rearm_trig", triggered, 0);
    chk("lvl0_rearm_done", done, 0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    gen_mode = 0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
